// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: four one-entry holding buffers feeding a registered CDB broadcast.
// Define CDB_ARB_RR_EN for round-robin arbitration; otherwise fixed priority int > ls > mult > div.
module cdb_arbiter #(
  parameter int W_DATA = 32,
  parameter int W_TAG  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              int_valid,
  input  logic [W_TAG-1:0]  int_tag,
  input  logic [W_DATA-1:0] int_data,
  input  logic              int_branch,
  input  logic              int_taken,
  input  logic              ls_valid,
  input  logic [W_TAG-1:0]  ls_tag,
  input  logic [W_DATA-1:0] ls_data,
  input  logic              mult_valid,
  input  logic [W_TAG-1:0]  mult_tag,
  input  logic [W_DATA-1:0] mult_data,
  input  logic              div_valid,
  input  logic [W_TAG-1:0]  div_tag,
  input  logic [W_DATA-1:0] div_data,
  output logic              int_ready,
  output logic              ls_ready,
  output logic              mult_ready,
  output logic              div_ready,
  output logic              cdb_valid,
  output logic [W_TAG-1:0]  cdb_tag,
  output logic [W_DATA-1:0] cdb_data,
  output logic              cdb_branch,
  output logic              cdb_branch_taken
);

  // Handshake: a unit's result is taken at a rising edge where its valid and
  // ready are both high; ready depends only on buffer state, never on valid.
  logic [3:0]        valid_v;
  logic [3:0]        ready_v;
  logic [3:0]        accept;
  logic [3:0]        full;
  logic [3:0]        grant;
  logic [W_TAG-1:0]  tag_in  [4];
  logic [W_DATA-1:0] data_in [4];
  logic [W_TAG-1:0]  tag_q   [4];
  logic [W_DATA-1:0] data_q  [4];
  logic              br_q;
  logic              tk_q;
  logic [1:0]        gnt_idx;
  logic              any_grant;

  assign valid_v = {div_valid, mult_valid, ls_valid, int_valid};
  assign tag_in[0]  = int_tag;
  assign tag_in[1]  = ls_tag;
  assign tag_in[2]  = mult_tag;
  assign tag_in[3]  = div_tag;
  assign data_in[0] = int_data;
  assign data_in[1] = ls_data;
  assign data_in[2] = mult_data;
  assign data_in[3] = div_data;

`ifdef CDB_ARB_RR_EN
  logic [1:0] rr_ptr;
  logic [1:0] idx;
  logic       found;

  // Search starts one past the last granted source.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= 4; k++) begin
      idx = rr_ptr + 2'(k);
      if (!found && full[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= 2'd3;
    end else if (any_grant) begin
      rr_ptr <= gnt_idx;
    end
  end
`else
  always_comb begin
    grant    = '0;
    grant[0] = full[0];
    grant[1] = full[1] & ~full[0];
    grant[2] = full[2] & ~|full[1:0];
    grant[3] = full[3] & ~|full[2:0];
  end
`endif

  assign any_grant = |grant;
  assign ready_v   = ~full | grant;
  assign accept    = valid_v & ready_v;

  assign int_ready  = ready_v[0];
  assign ls_ready   = ready_v[1];
  assign mult_ready = ready_v[2];
  assign div_ready  = ready_v[3];

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < 4; i++) begin
      if (grant[i]) gnt_idx = 2'(i);
    end
  end

  // A same-edge accept on the granted source wins: the entry is reloaded.
  always_ff @(posedge clk) begin
    if (reset) begin
      full <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (accept[i]) begin
          full[i] <= 1'b1;
        end else if (grant[i]) begin
          full[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (accept[i]) begin
        tag_q[i]  <= tag_in[i];
        data_q[i] <= data_in[i];
      end
    end
    if (accept[0]) begin
      br_q <= int_branch;
      tk_q <= int_taken;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || !any_grant) begin
      cdb_valid        <= 1'b0;
      cdb_tag          <= '0;
      cdb_data         <= '0;
      cdb_branch       <= 1'b0;
      cdb_branch_taken <= 1'b0;
    end else begin
      cdb_valid        <= 1'b1;
      cdb_tag          <= tag_q[gnt_idx];
      cdb_data         <= data_q[gnt_idx];
      cdb_branch       <= grant[0] & br_q;
      cdb_branch_taken <= grant[0] & br_q & tk_q;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed testbench for cdb_arbiter; covers both the fixed-priority and CDB_ARB_RR_EN builds.
module tb_cdb_arbiter;
  localparam int W_DATA = 32;
  localparam int W_TAG  = 6;

  logic              clk;
  logic              reset;
  logic              int_valid, ls_valid, mult_valid, div_valid;
  logic [W_TAG-1:0]  int_tag, ls_tag, mult_tag, div_tag;
  logic [W_DATA-1:0] int_data, ls_data, mult_data, div_data;
  logic              int_branch, int_taken;
  logic              int_ready, ls_ready, mult_ready, div_ready;
  logic              cdb_valid;
  logic [W_TAG-1:0]  cdb_tag;
  logic [W_DATA-1:0] cdb_data;
  logic              cdb_branch, cdb_branch_taken;

  int checks = 0;
  int errors = 0;
  logic [W_TAG-1:0] exp_q[$];

  cdb_arbiter #(.W_DATA(W_DATA), .W_TAG(W_TAG)) dut (
    .clk(clk), .reset(reset),
    .int_valid(int_valid), .int_tag(int_tag), .int_data(int_data),
    .int_branch(int_branch), .int_taken(int_taken),
    .ls_valid(ls_valid), .ls_tag(ls_tag), .ls_data(ls_data),
    .mult_valid(mult_valid), .mult_tag(mult_tag), .mult_data(mult_data),
    .div_valid(div_valid), .div_tag(div_tag), .div_data(div_data),
    .int_ready(int_ready), .ls_ready(ls_ready), .mult_ready(mult_ready), .div_ready(div_ready),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .cdb_branch(cdb_branch), .cdb_branch_taken(cdb_branch_taken)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    int_valid = 0; ls_valid = 0; mult_valid = 0; div_valid = 0;
    int_branch = 0; int_taken = 0;
  endtask

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic check_idle_cdb(input string name);
    check(name, {cdb_valid, cdb_branch, cdb_branch_taken, 26'(cdb_tag), cdb_data}, 64'h0);
  endtask

  logic [3:0] rdy;
  logic       seen;
  logic       int_acc;

  initial begin
    reset = 1;
    int_valid = 1; ls_valid = 1; mult_valid = 1; div_valid = 1;
    int_tag = 6'h21; ls_tag = 6'h22; mult_tag = 6'h23; div_tag = 6'h24;
    int_data = 32'h1; ls_data = 32'h2; mult_data = 32'h3; div_data = 32'h4;
    int_branch = 1; int_taken = 1;

    // Reset held two cycles with every valid high
    tick();
    rdy = {div_ready, mult_ready, ls_ready, int_ready};
    check("reset1_ready", 64'(rdy), 64'hF);
    check_idle_cdb("reset1_cdb");
    tick();
    rdy = {div_ready, mult_ready, ls_ready, int_ready};
    check("reset2_ready", 64'(rdy), 64'hF);
    check_idle_cdb("reset2_cdb");
    reset = 0;
    idle_inputs();
    tick();
    check_idle_cdb("post_reset_cdb");

    // Single ls result
    ls_valid = 1; ls_tag = 6'h05; ls_data = 32'hDEADBEEF;
    check("single_ls_ready", 64'(ls_ready), 64'h1);
    tick();
    ls_valid = 0;
    check("single_lat1_valid", 64'(cdb_valid), 64'h0);
    tick();
    check("single_valid", 64'(cdb_valid), 64'h1);
    check("single_tag", 64'(cdb_tag), 64'h05);
    check("single_data", 64'(cdb_data), 64'hDEADBEEF);
    check("single_branch", 64'(cdb_branch), 64'h0);
    tick();
    check_idle_cdb("single_after");

    // Branch forward, taken then not taken
    int_valid = 1; int_tag = 6'h11; int_data = 32'h40; int_branch = 1; int_taken = 1;
    tick();
    idle_inputs();
    tick();
    check("br_t_valid", 64'(cdb_valid), 64'h1);
    check("br_t_tag", 64'(cdb_tag), 64'h11);
    check("br_t_data", 64'(cdb_data), 64'h40);
    check("br_t_branch", 64'(cdb_branch), 64'h1);
    check("br_t_taken", 64'(cdb_branch_taken), 64'h1);
    tick();
    int_valid = 1; int_tag = 6'h11; int_data = 32'h40; int_branch = 1; int_taken = 0;
    tick();
    idle_inputs();
    tick();
    check("br_nt_tag", 64'(cdb_tag), 64'h11);
    check("br_nt_branch", 64'(cdb_branch), 64'h1);
    check("br_nt_taken", 64'(cdb_branch_taken), 64'h0);
    tick();

    // Fresh reset so round-robin starts at int
    reset = 1;
    tick();
    reset = 0;
    tick();

    // Four-way collision
    int_valid = 1; ls_valid = 1; mult_valid = 1; div_valid = 1;
    int_tag = 6'd1; ls_tag = 6'd2; mult_tag = 6'd3; div_tag = 6'd4;
    int_data = 32'h101; ls_data = 32'h102; mult_data = 32'h103; div_data = 32'h104;
    for (int i = 1; i <= 4; i++) exp_q.push_back(6'(i));
    tick();
    idle_inputs();
    check("coll_c0_valid", 64'(cdb_valid), 64'h0);
    rdy = {div_ready, mult_ready, ls_ready, int_ready};
    check("coll_c0_ready", 64'(rdy), 64'b0001);
    tick();
    check("coll_b1_tag", 64'(cdb_tag), 64'(exp_q.pop_front()));
    check("coll_b1_data", 64'(cdb_data), 64'h101);
    rdy = {div_ready, mult_ready, ls_ready, int_ready};
    check("coll_c1_ready", 64'(rdy), 64'b0011);
    tick();
    check("coll_b2_tag", 64'(cdb_tag), 64'(exp_q.pop_front()));
    rdy = {div_ready, mult_ready, ls_ready, int_ready};
    check("coll_c2_ready", 64'(rdy), 64'b0111);
    tick();
    check("coll_b3_tag", 64'(cdb_tag), 64'(exp_q.pop_front()));
    check("coll_b3_valid", 64'(cdb_valid), 64'h1);
    rdy = {div_ready, mult_ready, ls_ready, int_ready};
    check("coll_c3_ready", 64'(rdy), 64'b1111);
    tick();
    check("coll_b4_tag", 64'(cdb_tag), 64'(exp_q.pop_front()));
    check("coll_b4_data", 64'(cdb_data), 64'h104);
    tick();
    check_idle_cdb("coll_after");

    // Fairness: int streams, div requests once
    int_valid = 1; int_tag = 6'h20; int_data = 32'h500; int_branch = 0;
    div_valid = 1; div_tag = 6'h3F; div_data = 32'hD1;
    check("fair_div_ready", 64'(div_ready), 64'h1);
    seen = 0;
    int_acc = int_ready;
    tick();
    div_valid = 0;
    if (int_acc) int_tag = int_tag + 6'd1;
`ifdef CDB_ARB_RR_EN
    for (int k = 0; k < 4; k++) begin
      int_acc = int_ready;
      tick();
      if (int_acc) int_tag = int_tag + 6'd1;
      if (cdb_valid && cdb_tag == 6'h3F) seen = 1;
    end
    check("fair_rr_div_seen", 64'(seen), 64'h1);
`else
    for (int k = 0; k < 6; k++) begin
      int_acc = int_ready;
      tick();
      if (int_acc) int_tag = int_tag + 6'd1;
      if (cdb_valid && cdb_tag == 6'h3F) seen = 1;
    end
    check("fair_fix_div_blocked", 64'(seen), 64'h0);
    check("fair_fix_div_ready", 64'(div_ready), 64'h0);
    check("fair_fix_int_valid", 64'(cdb_valid), 64'h1);
`endif
    idle_inputs();
    for (int k = 0; k < 4; k++) tick();
    check_idle_cdb("fair_drained");

    // Reset mid-operation discards buffered results
    ls_valid = 1; mult_valid = 1; div_valid = 1;
    ls_tag = 6'h2A; mult_tag = 6'h2B; div_tag = 6'h2C;
    tick();
    idle_inputs();
    rdy = {div_ready, mult_ready, ls_ready, int_ready};
    check("mid_buffered_ready", 64'(rdy), 64'b0011);
    reset = 1;
    tick();
    reset = 0;
    check_idle_cdb("mid_reset_cdb");
    rdy = {div_ready, mult_ready, ls_ready, int_ready};
    check("mid_reset_ready", 64'(rdy), 64'hF);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("mid_no_bcast", 64'(cdb_valid), 64'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Common data bus arbiter for the out-of-order core. It collects completed results from the four execution units (integer, load/store, multiply, divide) through one-entry holding buffers. Each cycle it grants one buffered result to a registered broadcast on the CDB, which dispatch and all issue queues snoop. Results from the integer unit carry branch-resolution fields that are forwarded to dispatch.

## Interface
Parameters:
- W_DATA, 32, result data width
- W_TAG, 6, rename tag width

Ports (one clock, `clk`; reset `reset` is synchronous and active-high):
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- int_valid / ls_valid / mult_valid / div_valid  input  1 each  unit presents a result
- int_tag / ls_tag / mult_tag / div_tag  input  W_TAG each  destination rename tag
- int_data / ls_data / mult_data / div_data  input  W_DATA each  result value
- int_branch  input  1  integer result is a resolved branch
- int_taken  input  1  branch outcome (meaningful only with int_branch)
- int_ready / ls_ready / mult_ready / div_ready  output  1 each  buffer can accept this cycle
- cdb_valid  output  1  broadcast valid
- cdb_tag  output  W_TAG  broadcast tag
- cdb_data  output  W_DATA  broadcast data
- cdb_branch  output  1  broadcast is a branch resolution
- cdb_branch_taken  output  1  branch taken

## Operation
- Source index: 0 = int, 1 = ls, 2 = mult, 3 = div.
- Per source, a holding buffer holds {full, tag, data}; int also holds {branch, taken}.
- grant[i] is combinational from the full bits and the priority state only. It is one-hot, or zero when all buffers are empty.
- src_ready[i] = ~full[i] | grant[i]. It depends on state only, never on src_valid.
- Accept: src_valid & src_ready at a rising edge loads the buffer and sets full.
- Grant: at the edge, the granted buffer is copied to the CDB output registers and full is cleared, unless a new accept on the same source reloads it in that same edge.
- Units hold valid, tag and data stable until ready is seen high at the edge.
- CDB outputs are registered. When no buffer is full, the next cycle has cdb_valid = 0, and cdb_tag, cdb_data, cdb_branch and cdb_branch_taken are driven to 0.
- cdb_branch and cdb_branch_taken are 1 only when the integer source is granted and its buffered branch (and taken) bit is 1. Other sources always drive them 0.
- Reset:
  - All full bits are cleared, so every ready output is 1.
  - All CDB outputs are 0.
  - The round-robin pointer is set to 3, so int has highest priority first.
  - Reset mid-operation discards buffered results with no broadcast.

## Timing
- Uncontended latency: accept at edge E, cdb_valid high during the cycle after edge E+1 (2 cycles).
- Sustained throughput is one result per source per cycle while that source wins every grant. Overall throughput is one broadcast per cycle.
- A losing source keeps its buffer full and its ready low until it is granted. In the grant cycle its ready is high, so back-to-back refill is possible.
- Four simultaneous accepts are all buffered. They are broadcast over the next 4 cycles in priority order, with no gaps.
- Simultaneous grant and accept on one source is legal: the old entry is broadcast and the new entry is buffered.

## Configuration
- CDB_ARB_RR_EN defined:
  - Round-robin arbitration. Priority starts at the index after the last granted source, wrapping 3 -> 0.
  - The pointer updates only on a grant.
  - Any continuously requesting source is granted within 4 cycles.
- CDB_ARB_RR_EN undefined:
  - Fixed priority int > ls > mult > div, with no pointer state.
  - A lower source may starve under continuous higher traffic; this is accepted.

## Test plan
- Reset: assert reset for 2 cycles with all unit valids at 1. Required: all ready = 1, cdb_valid = 0 and all CDB fields = 0 throughout, and no broadcast in the first cycle after release.
- Single result: ls_valid with tag 0x05 and data 0xDEADBEEF, accepted at edge E. Required: cdb_valid = 1, tag 0x05, data 0xDEADBEEF, cdb_branch = 0 in the cycle after E+1, then cdb_valid = 0.
- Branch forward: int result with tag 0x11, data 0x40, branch = 1, taken = 1. Required: cdb_branch = 1 and cdb_branch_taken = 1 with tag 0x11. Repeat with taken = 0 and require cdb_branch_taken = 0.
- Four-way collision: all four valid in the same cycle with tags 1/2/3/4, valids then dropped. Required: four consecutive broadcasts. With RR after reset the tag order is 1, 2, 3, 4; in fixed mode it is also 1, 2, 3, 4. mult_ready and div_ready stay low until their grant cycles.
- Fairness (RR only): int valid continuously with incrementing tags and div valid once with tag 0x3F. Required: 0x3F is broadcast within 4 cycles of acceptance. In fixed mode, div stays blocked while int streams.
- Reset mid-operation: buffer 3 results, then assert reset. Required: none of those 3 tags appear on the CDB, and all ready = 1 after reset.
